// File: rtl/fetch_buffer_if.sv
// Fetch buffer bus: PC/instruction capture side, decode side and stats outputs.
// The fetch_buffer uses the slave modport; the surrounding pipeline (or a bench)
// uses the master modport.
interface fetch_buffer_if #(
    parameter int unsigned XLEN = 5,
    parameter int unsigned ILEN = 32
);
    logic [XLEN-1:0] F_pc;
    logic [ILEN-1:0] imem_rdata;
    logic            EX_taken;
    logic            stall_D;
    logic [XLEN-1:0] pc_seq;
    logic            fetch_hold;
    logic            D_valid;
    logic [XLEN-1:0] D_pc;
    logic [ILEN-1:0] D_instr;
    logic [15:0]     flush_cnt;
    logic [15:0]     full_cnt;

    modport master (
        output F_pc, imem_rdata, EX_taken, stall_D,
        input  pc_seq, fetch_hold, D_valid, D_pc, D_instr, flush_cnt, full_cnt
    );

    modport slave (
        input  F_pc, imem_rdata, EX_taken, stall_D,
        output pc_seq, fetch_hold, D_valid, D_pc, D_instr, flush_cnt, full_cnt
    );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: captures {F_pc, imem_rdata} into a small FIFO each cycle and
// presents the head entry to decode. A taken branch/jump drops all queued
// entries. Optional flush/full statistics counters are built only when
// FETCH_BUF_STATS_EN is defined; otherwise both counters read 0.
module fetch_buffer #(
    parameter int unsigned XLEN  = 5,
    parameter int unsigned ILEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input logic           clk,
    input logic           rst,
    fetch_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } entry_t;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full, empty, push, pop;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);
    // A full FIFO never accepts a push, even when it pops in the same cycle;
    // the PC register holds instead, so the slot refills one cycle later.
    assign push  = !bus.EX_taken && !full;
    assign pop   = !empty && !bus.stall_D && !bus.EX_taken;

    assign bus.pc_seq     = bus.F_pc + XLEN'(1);
    assign bus.fetch_hold = full;
    assign bus.D_valid    = !empty;

    // Head entry to decode, forced to zero while the FIFO is empty.
    always_comb begin
        bus.D_pc    = '0;
        bus.D_instr = '0;
        if (!empty) begin
            bus.D_pc    = mem_q[rd_ptr_q].pc;
            bus.D_instr = mem_q[rd_ptr_q].instr;
        end
    end

    // Next-state for storage, pointers and occupancy; a flush overrides all.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.EX_taken) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: bus.F_pc, instr: bus.imem_rdata};
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef FETCH_BUF_STATS_EN
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic [15:0] full_cnt_q, full_cnt_d;

    // Saturating event counters: flushes and held (full) cycles.
    always_comb begin
        flush_cnt_d = flush_cnt_q;
        full_cnt_d  = full_cnt_q;
        if (bus.EX_taken && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
        if (full && (full_cnt_q != 16'hFFFF)) begin
            full_cnt_d = full_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_cnt_q <= '0;
            full_cnt_q  <= '0;
        end else begin
            flush_cnt_q <= flush_cnt_d;
            full_cnt_q  <= full_cnt_d;
        end
    end

    assign bus.flush_cnt = flush_cnt_q;
    assign bus.full_cnt  = full_cnt_q;
`else
    assign bus.flush_cnt = '0;
    assign bus.full_cnt  = '0;
`endif

endmodule
